// File: rtl/rename_map_table_if.sv
// Rename map table port bundle.
// Every request (dst_valid lanes, ckpt_save, ckpt_release, restore_valid) is a
// single-cycle strobe sampled at the rising clock edge with no backpressure:
// the requester checks ckpt_full / ckpt_count before saving or releasing, and
// the table answers any illegal request with a one-cycle ckpt_err pulse.
// Lane k of every packed bus occupies bits [k*W +: W].
interface rename_map_table_if #(
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int NUM_CKPTS    = 4
);
    localparam int AW = $clog2(NUM_AREGS);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(NUM_CKPTS);
    localparam int LW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1;

    logic [RENAME_WIDTH*AW-1:0] src1_areg;
    logic [RENAME_WIDTH*AW-1:0] src2_areg;
    logic [RENAME_WIDTH*PW-1:0] src1_preg;
    logic [RENAME_WIDTH*PW-1:0] src2_preg;
    logic [RENAME_WIDTH-1:0]    dst_valid;
    logic [RENAME_WIDTH*AW-1:0] dst_areg;
    logic [RENAME_WIDTH*PW-1:0] dst_new_preg;
    logic [RENAME_WIDTH*PW-1:0] dst_old_preg;
    logic                       ckpt_save;
    logic [LW-1:0]              ckpt_lane;
    logic [CW-1:0]              ckpt_id;
    logic                       ckpt_full;
    logic [CW:0]                ckpt_count;
    logic                       restore_valid;
    logic [CW-1:0]              restore_id;
    logic                       ckpt_release;
    logic                       ckpt_err;

    // Rename stage side: issues lookups, writes and checkpoint requests.
    modport master (
        output src1_areg, src2_areg, dst_valid, dst_areg, dst_new_preg,
        output ckpt_save, ckpt_lane, restore_valid, restore_id, ckpt_release,
        input  src1_preg, src2_preg, dst_old_preg,
        input  ckpt_id, ckpt_full, ckpt_count, ckpt_err
    );

    // Map table side.
    modport slave (
        input  src1_areg, src2_areg, dst_valid, dst_areg, dst_new_preg,
        input  ckpt_save, ckpt_lane, restore_valid, restore_id, ckpt_release,
        output src1_preg, src2_preg, dst_old_preg,
        output ckpt_id, ckpt_full, ckpt_count, ckpt_err
    );
endinterface

// File: rtl/rename_map_table.sv
// Register rename map table with intra-group bypass and a circular buffer of
// branch checkpoints (head = oldest live, tail = next id to hand out).
// Optional feature: define RMT_ZERO_REG_EN to hard-wire areg 0 to preg 0.
module rename_map_table #(
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int NUM_CKPTS    = 4
) (
    input logic               clk,
    input logic               rst,
    rename_map_table_if.slave bus
);
    localparam int AW = $clog2(NUM_AREGS);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(NUM_CKPTS);

    logic [PW-1:0] table_q [NUM_AREGS];
    logic [PW-1:0] table_d [NUM_AREGS];
    logic [PW-1:0] snap_q  [NUM_CKPTS][NUM_AREGS];
    // stage[k] = table after applying the writes of lanes 0..k
    logic [PW-1:0] stage   [RENAME_WIDTH][NUM_AREGS];

    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          snap_we;

    logic [RENAME_WIDTH-1:0] wr_en;
    logic [AW-1:0] dst_a  [RENAME_WIDTH];
    logic [PW-1:0] dst_p  [RENAME_WIDTH];
    logic [AW-1:0] src1_a [RENAME_WIDTH];
    logic [AW-1:0] src2_a [RENAME_WIDTH];
    logic [PW-1:0] src1_p [RENAME_WIDTH];
    logic [PW-1:0] src2_p [RENAME_WIDTH];
    logic [PW-1:0] old_p  [RENAME_WIDTH];

    logic          full;
    logic [CW-1:0] rdiff;
    logic          restore_live;
    logic          save_ok;
    logic          rel_ok;

    assign full         = (count_q == (CW+1)'(NUM_CKPTS));
    // Distance of the requested id from the oldest live checkpoint.
    assign rdiff        = bus.restore_id - head_q;
    assign restore_live = ({1'b0, rdiff} < count_q);

    // Unpack lane fields and decide which lanes really write the table.
    always_comb begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            src1_a[k] = bus.src1_areg[k*AW +: AW];
            src2_a[k] = bus.src2_areg[k*AW +: AW];
            dst_a[k]  = bus.dst_areg[k*AW +: AW];
            dst_p[k]  = bus.dst_new_preg[k*PW +: PW];
`ifdef RMT_ZERO_REG_EN
            wr_en[k]  = bus.dst_valid[k] && (dst_a[k] != '0);
`else
            wr_en[k]  = bus.dst_valid[k];
`endif
        end
    end

    // Lookups: table value, overridden by the highest older lane writing the same areg.
    always_comb begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            src1_p[k] = table_q[src1_a[k]];
            src2_p[k] = table_q[src2_a[k]];
            old_p[k]  = table_q[dst_a[k]];
            for (int j = 0; j < k; j++) begin
                if (wr_en[j] && (dst_a[j] == src1_a[k])) src1_p[k] = dst_p[j];
                if (wr_en[j] && (dst_a[j] == src2_a[k])) src2_p[k] = dst_p[j];
                if (wr_en[j] && (dst_a[j] == dst_a[k]))  old_p[k]  = dst_p[j];
            end
`ifdef RMT_ZERO_REG_EN
            if (src1_a[k] == '0) src1_p[k] = '0;
            if (src2_a[k] == '0) src2_p[k] = '0;
            if (dst_a[k] == '0)  old_p[k]  = '0;
`endif
        end
    end

    // Pack lookup results onto the lane buses.
    always_comb begin
        bus.src1_preg    = '0;
        bus.src2_preg    = '0;
        bus.dst_old_preg = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            bus.src1_preg[k*PW +: PW]    = src1_p[k];
            bus.src2_preg[k*PW +: PW]    = src2_p[k];
            bus.dst_old_preg[k*PW +: PW] = old_p[k];
        end
    end

    // Progressive table images; later lanes overwrite earlier ones.
    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) begin
            if (wr_en[0] && (dst_a[0] == AW'(i))) stage[0][i] = dst_p[0];
            else                                   stage[0][i] = table_q[i];
        end
        for (int k = 1; k < RENAME_WIDTH; k++) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                if (wr_en[k] && (dst_a[k] == AW'(i))) stage[k][i] = dst_p[k];
                else                                   stage[k][i] = stage[k-1][i];
            end
        end
    end

    // Next-state: restore outranks writes and saves; illegal requests only raise err.
    always_comb begin
        table_d = table_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = 1'b0;
        snap_we = 1'b0;
        save_ok = 1'b0;
        rel_ok  = 1'b0;
        if (bus.restore_valid) begin
            if (restore_live) begin
                table_d = snap_q[bus.restore_id];
                tail_d  = bus.restore_id + 1'b1;
                count_d = {1'b0, rdiff} + 1'b1;
                // The restored checkpoint is live, so a release is always legal here.
                if (bus.ckpt_release) begin
                    head_d  = head_q + 1'b1;
                    count_d = {1'b0, rdiff};
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            table_d = stage[RENAME_WIDTH-1];
            save_ok = bus.ckpt_save && !full;
            rel_ok  = bus.ckpt_release && (count_q != '0);
            if ((bus.ckpt_save && full) || (bus.ckpt_release && (count_q == '0))) begin
                err_d = 1'b1;
            end
            if (save_ok) begin
                snap_we = 1'b1;
                tail_d  = tail_q + 1'b1;
            end
            if (rel_ok) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + (CW+1)'(save_ok) - (CW+1)'(rel_ok);
        end
    end

    // Architectural state and checkpoint pointers; reset restores identity mapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                table_q[i] <= PW'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            table_q <= table_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Snapshot storage; contents are meaningless until saved, so no reset.
    always_ff @(posedge clk) begin
        if (rst && snap_we) begin
            snap_q[tail_q] <= stage[bus.ckpt_lane];
        end
    end

    assign bus.ckpt_id    = tail_q;
    assign bus.ckpt_full  = full;
    assign bus.ckpt_count = count_q;
    assign bus.ckpt_err   = err_q;
endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table at default parameters.
module tb_rename_map_table;
    localparam int AW = 5;
    localparam int PW = 6;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rename_map_table_if bus ();

    rename_map_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src1_areg     = '0;
        bus.src2_areg     = '0;
        bus.dst_valid     = '0;
        bus.dst_areg      = '0;
        bus.dst_new_preg  = '0;
        bus.ckpt_save     = 1'b0;
        bus.ckpt_lane     = '0;
        bus.restore_valid = 1'b0;
        bus.restore_id    = '0;
        bus.ckpt_release  = 1'b0;
    endtask

    task automatic set_src1(input int k, input logic [AW-1:0] a);
        bus.src1_areg[k*AW +: AW] = a;
    endtask

    task automatic set_src2(input int k, input logic [AW-1:0] a);
        bus.src2_areg[k*AW +: AW] = a;
    endtask

    task automatic set_dst(input int k, input logic [AW-1:0] a, input logic [PW-1:0] p);
        bus.dst_valid[k]             = 1'b1;
        bus.dst_areg[k*AW +: AW]     = a;
        bus.dst_new_preg[k*PW +: PW] = p;
    endtask

    function automatic logic [PW-1:0] src1_of(input int k);
        return bus.src1_preg[k*PW +: PW];
    endfunction

    // Idle cycle lookup of one areg on lane 0.
    task automatic read_a(input logic [AW-1:0] a, input logic [PW-1:0] exp, input string tag);
        idle();
        set_src1(0, a);
        #1;
        chk(tag, src1_of(0), exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b0;
        // activity during reset must be discarded
        set_dst(0, 9, 60);
        bus.ckpt_save = 1'b1;
        tick();
        tick();
        chk("rst_count", bus.ckpt_count, 0);
        chk("rst_full", bus.ckpt_full, 0);
        chk("rst_err", bus.ckpt_err, 0);
        chk("rst_id", bus.ckpt_id, 0);
        idle();
        rst = 1'b1;

        // identity mapping after reset
        set_src1(0, 5);
        set_src1(1, 5);
        set_src2(1, 31);
        #1;
        chk("rd_a5_l0", src1_of(0), 5);
        chk("rd_a5_l1", src1_of(1), 5);
        chk("rd_a31_src2_l1", bus.src2_preg[PW +: PW], 31);
        read_a(9, 9, "rst_drops_write");

        // intra-group bypass and highest-lane-wins
        idle();
        set_dst(0, 3, 40);
        set_dst(1, 3, 41);
        set_src1(0, 3);
        set_src1(1, 3);
        #1;
        chk("byp_src1_l1", src1_of(1), 40);
        chk("byp_old_l1", bus.dst_old_preg[PW +: PW], 40);
        chk("byp_src1_l0", src1_of(0), 3);
        chk("byp_old_l0", bus.dst_old_preg[0 +: PW], 3);
        tick();
        read_a(3, 41, "high_lane_wins");

        // snapshot after lane 0 only
        idle();
        set_dst(0, 7, 50);
        set_dst(1, 7, 51);
        bus.ckpt_save = 1'b1;
        bus.ckpt_lane = 1'b0;
        #1;
        chk("save_id0", bus.ckpt_id, 0);
        tick();
        idle();
        #1;
        chk("save_count", bus.ckpt_count, 1);
        chk("save_tail", bus.ckpt_id, 1);
        read_a(7, 51, "a7_live");
        idle();
        set_dst(0, 7, 52);
        set_dst(1, 3, 42);
        tick();
        // restore with a write and a save in the same cycle: both ignored
        idle();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 0;
        bus.ckpt_save     = 1'b1;
        set_dst(0, 8, 55);
        tick();
        idle();
        #1;
        chk("rest0_count", bus.ckpt_count, 1);
        chk("rest0_tail", bus.ckpt_id, 1);
        chk("rest0_err", bus.ckpt_err, 0);
        read_a(7, 50, "rest0_a7");
        read_a(3, 41, "rest0_a3");
        read_a(8, 8, "rest0_drops_write");

        // release, then release when empty
        idle();
        bus.ckpt_release = 1'b1;
        tick();
        idle();
        #1;
        chk("rel_count", bus.ckpt_count, 0);
        chk("rel_err", bus.ckpt_err, 0);
        bus.ckpt_release = 1'b1;
        tick();
        idle();
        #1;
        chk("rel_empty_err", bus.ckpt_err, 1);
        chk("rel_empty_count", bus.ckpt_count, 0);
        tick();
        chk("err_one_cycle", bus.ckpt_err, 0);

        // fill all four checkpoints (head=1, tail=1 -> ids 1,2,3,0)
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.ckpt_save = 1'b1;
            #1;
            chk("fill_id", bus.ckpt_id, (1 + i) % 4);
            tick();
            idle();
            #1;
            chk("fill_count", bus.ckpt_count, i + 1);
        end
        chk("full_flag", bus.ckpt_full, 1);
        bus.ckpt_save = 1'b1;
        tick();
        idle();
        #1;
        chk("ovf_err", bus.ckpt_err, 1);
        chk("ovf_count", bus.ckpt_count, 4);
        chk("ovf_id", bus.ckpt_id, 1);
        bus.ckpt_release = 1'b1;
        tick();
        idle();
        #1;
        chk("drain_count", bus.ckpt_count, 3);
        chk("drain_full", bus.ckpt_full, 0);
        bus.ckpt_save    = 1'b1;
        bus.ckpt_release = 1'b1;
        tick();
        idle();
        #1;
        chk("balance_count", bus.ckpt_count, 3);
        chk("balance_id", bus.ckpt_id, 2);
        chk("balance_err", bus.ckpt_err, 0);

        // fresh pointers: save ids 0,1,2 each snapshotting a12 after lane 1
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            set_dst(1, 12, PW'(30 + i));
            bus.ckpt_save = 1'b1;
            bus.ckpt_lane = 1'b1;
            tick();
        end
        idle();
        bus.ckpt_release = 1'b1;
        tick();
        idle();
        set_dst(0, 12, 63);
        tick();
        idle();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 2;
        tick();
        idle();
        #1;
        chk("rest2_count", bus.ckpt_count, 2);
        chk("rest2_tail", bus.ckpt_id, 3);
        chk("rest2_err", bus.ckpt_err, 0);
        read_a(12, 32, "rest2_a12");
        idle();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 0;
        tick();
        idle();
        #1;
        chk("rest_dead0_err", bus.ckpt_err, 1);
        chk("rest_dead0_count", bus.ckpt_count, 2);
        chk("rest_dead0_tail", bus.ckpt_id, 3);
        bus.restore_valid = 1'b1;
        bus.restore_id    = 3;
        tick();
        idle();
        #1;
        chk("rest_dead3_err", bus.ckpt_err, 1);
        chk("rest_dead3_count", bus.ckpt_count, 2);
        // restore id 1 plus release in the same cycle
        bus.restore_valid = 1'b1;
        bus.restore_id    = 1;
        bus.ckpt_release  = 1'b1;
        tick();
        idle();
        #1;
        chk("rest1rel_count", bus.ckpt_count, 0);
        chk("rest1rel_tail", bus.ckpt_id, 2);
        chk("rest1rel_err", bus.ckpt_err, 0);
        read_a(12, 31, "rest1rel_a12");
        // head must now be 2: save id 2 and restore it -> one live checkpoint
        idle();
        bus.ckpt_save = 1'b1;
        tick();
        idle();
        bus.restore_valid = 1'b1;
        bus.restore_id    = 2;
        tick();
        idle();
        #1;
        chk("head2_count", bus.ckpt_count, 1);
        chk("head2_tail", bus.ckpt_id, 3);

        // areg 0 handling
        idle();
        set_dst(0, 0, 33);
        set_src1(1, 0);
        #1;
`ifdef RMT_ZERO_REG_EN
        chk("zero_byp_l1", src1_of(1), 0);
        chk("zero_old_l0", bus.dst_old_preg[0 +: PW], 0);
        tick();
        read_a(0, 0, "zero_read");
`else
        chk("a0_byp_l1", src1_of(1), 33);
        chk("a0_old_l0", bus.dst_old_preg[0 +: PW], 0);
        tick();
        read_a(0, 33, "a0_read");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rename_map_table.md
RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_AREGS, 32, architectural registers.
- NUM_PREGS, 64, physical registers (>= NUM_AREGS).
- RENAME_WIDTH, 2, instructions renamed per cycle.
- NUM_CKPTS, 4, branch checkpoints (power of 2).

REQ-002 The block SHALL derive these widths: AW=$clog2(NUM_AREGS), PW=$clog2(NUM_PREGS), CW=$clog2(NUM_CKPTS), LW=max(1,$clog2(RENAME_WIDTH)). Lane k SHALL occupy bits [k*W +: W] of every packed bus.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous, active-low reset.
- src1_areg, in, RENAME_WIDTH*AW, source-1 arch reg per lane.
- src2_areg, in, RENAME_WIDTH*AW, source-2 arch reg per lane.
- src1_preg, out, RENAME_WIDTH*PW, source-1 alias per lane.
- src2_preg, out, RENAME_WIDTH*PW, source-2 alias per lane.
- dst_valid, in, RENAME_WIDTH, lane writes a new mapping.
- dst_areg, in, RENAME_WIDTH*AW, destination arch reg per lane.
- dst_new_preg, in, RENAME_WIDTH*PW, newly allocated preg per lane.
- dst_old_preg, out, RENAME_WIDTH*PW, prior alias of dst_areg (to free list at commit).
- ckpt_save, in, 1, take checkpoint after lane ckpt_lane.
- ckpt_lane, in, LW, lane holding the branch.
- ckpt_id, out, CW, id that the current ckpt_save will receive.
- ckpt_full, out, 1, all checkpoints in use.
- ckpt_count, out, CW+1, live checkpoints.
- restore_valid, in, 1, mispredict recovery.
- restore_id, in, CW, checkpoint to restore.
- ckpt_release, in, 1, oldest branch resolved correctly; free the oldest checkpoint.
- ckpt_err, out, 1, registered one-cycle pulse on an illegal request.

Function
REQ-004 Reads SHALL be combinational from the current table, with intra-group bypass: lane k's src and dst_old lookups SHALL return dst_new_preg of the highest lane j<k with dst_valid[j] and matching dst_areg; otherwise the table value.
REQ-005 Writes SHALL commit at the rising edge; when several lanes in a cycle write the same areg, the highest lane SHALL win.
REQ-006 The checkpoints SHALL form a circular buffer with head (oldest) and tail (next id); ckpt_id SHALL equal tail.
REQ-007 On ckpt_save with ckpt_full low, the snapshot SHALL equal the table after applying writes of lanes 0..ckpt_lane only; tail SHALL increment mod NUM_CKPTS and count SHALL increment.
REQ-008 On ckpt_release with count>0, head SHALL increment and count SHALL decrement.
REQ-009 A save and a release in the same cycle SHALL leave count unchanged.
REQ-010 On restore_valid with restore_id live, the table SHALL load the snapshot at restore_id, tail SHALL become restore_id+1, and count SHALL become (restore_id-head mod NUM_CKPTS)+1; that checkpoint SHALL stay live and all younger checkpoints SHALL be discarded.
REQ-011 Restore SHALL take priority: dst writes and ckpt_save in the same cycle SHALL be ignored; a concurrent ckpt_release SHALL still apply, after the restore.
REQ-012 A save when full, a release when empty, or a restore of a non-live id SHALL not change state and SHALL pulse ckpt_err.
REQ-013 ckpt_full SHALL equal (count==NUM_CKPTS); the count SHALL never wrap.

Reset
REQ-014 While rst=0 at a clock edge, table[i] SHALL be set to i and head, tail and count SHALL be set to 0; ckpt_full and ckpt_err SHALL be 0, and snapshot contents SHALL be don't-care.
REQ-015 Reset SHALL override every in-flight save, restore or write in the same cycle.

Configuration
REQ-016 When RMT_ZERO_REG_EN is defined, areg 0 SHALL always read preg 0, writes to areg 0 SHALL be dropped and excluded from bypass, and dst_old_preg for areg 0 SHALL read 0. When it is undefined, areg 0 SHALL behave like any other register.

Verification
REQ-017 The bench SHALL cover these directed scenarios at default parameters:
- Reset release, read areg 5 on both lanes -> src1_preg=5 on both lanes.
- Lane0 writes a3->p40 and lane1 reads src1=a3 and dst a3->p41 in the same cycle -> lane1 src1_preg=40 and dst_old_preg=40; the next cycle reads a3=41.
- Lane0 writes a7->p50, ckpt_save with ckpt_lane=0, lane1 writes a7->p51, later restore to that id -> a7 reads 50 and ckpt_count=1.
- Four saves with no releases -> ckpt_full=1; a fifth save -> ckpt_err pulse and ckpt_count stays 4.
- Saves ids 0,1,2, release, then restore id 2 -> head=1, tail=3, ckpt_count=2; restore id 0 -> ckpt_err.
- With RMT_ZERO_REG_EN defined, write a0->p33 -> a0 still reads 0.
